// File: rtl/int_pending_ctrl.sv
// rtl/int_pending_ctrl.sv - ESTAT.IS source collection and handshaked interrupt request
// Holds the SWI/TI/IPI pending bits, synchronises HWI lines, and raises int_req towards the commit unit.
module int_pending_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int BLOCK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_hwi_in,
    input  logic        i_ipi_in,
    input  logic        i_ipi_clr,
    input  logic [1:0]  i_swi,
    input  logic [1:0]  i_swi_clr,
    input  logic        i_ti,
    input  logic        i_ti_clr,
    input  logic        i_ie,
    input  logic [12:0] i_lie,
    output logic [12:0] o_is,
    output logic        o_int_req,
    input  logic        i_int_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BLOCK = 2'd2
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(BLOCK_CYCLES - 1);

    logic [SYNC_STAGES-1:0][7:0] r_hwi_sync;
    logic [1:0]                  r_swi;
    logic                        r_ti;
    logic                        r_ipi;
    state_t                      r_state;
    logic [2:0]                  r_cnt;

    state_t                      w_state_next;
    logic [2:0]                  w_cnt_next;
    logic [12:0]                 w_is;
    logic                        w_pend;

    // Set has priority over clear so a new event arriving with a clear is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hwi_sync <= '0;
            r_swi      <= 2'b00;
            r_ti       <= 1'b0;
            r_ipi      <= 1'b0;
        end else begin
            r_hwi_sync <= {r_hwi_sync[SYNC_STAGES-2:0], i_hwi_in};
            r_swi      <= (r_swi & ~i_swi_clr) | i_swi;
            r_ti       <= i_ti | (r_ti & ~i_ti_clr);
            r_ipi      <= i_ipi_in | (r_ipi & ~i_ipi_clr);
        end
    end

    assign w_is   = {r_ipi, r_ti, 1'b0, r_hwi_sync[SYNC_STAGES-1], r_swi};
    assign w_pend = i_ie & (|(w_is & i_lie));
    assign o_is   = w_is;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // BLOCK masks the request while the core's IE clear is still in flight.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pend) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_int_ack) begin
                    w_state_next = ST_BLOCK;
                    w_cnt_next   = CNT_LOAD;
                end else if (!w_pend) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_BLOCK: begin
                if (r_cnt == 3'd0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 3'd0;
            end
        endcase
    end

    assign o_int_req = (r_state == ST_REQ);

endmodule

// File: tb/tb_int_pending_ctrl.sv
// tb/tb_int_pending_ctrl.sv - self-checking bench for int_pending_ctrl
module tb_int_pending_ctrl;

    logic        clk;
    logic        rst_n;
    logic [7:0]  hwi_in;
    logic        ipi_in;
    logic        ipi_clr;
    logic [1:0]  swi;
    logic [1:0]  swi_clr;
    logic        ti;
    logic        ti_clr;
    logic        ie;
    logic [12:0] lie;
    logic [12:0] is_o;
    logic        int_req;
    logic        int_ack;

    int errors;
    int checks;

    typedef struct {
        logic [1:0]  swi;
        logic [1:0]  swi_clr;
        logic        ti;
        logic        ti_clr;
        logic        ipi;
        logic        ipi_clr;
        logic        ie;
        logic [12:0] lie;
        logic        ack;
        logic [12:0] exp_is;
        logic        exp_req;
    } vec_t;

    vec_t vq[$];

    int_pending_ctrl #(
        .SYNC_STAGES (2),
        .BLOCK_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_hwi_in (hwi_in),
        .i_ipi_in (ipi_in),
        .i_ipi_clr(ipi_clr),
        .i_swi    (swi),
        .i_swi_clr(swi_clr),
        .i_ti     (ti),
        .i_ti_clr (ti_clr),
        .i_ie     (ie),
        .i_lie    (lie),
        .o_is     (is_o),
        .o_int_req(int_req),
        .i_int_ack(int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] s, input logic [1:0] sc, input logic t, input logic tc,
                       input logic p, input logic pc, input logic e, input logic [12:0] l,
                       input logic a, input logic [12:0] xis, input logic xreq);
        vec_t v;
        v.swi = s; v.swi_clr = sc; v.ti = t; v.ti_clr = tc; v.ipi = p; v.ipi_clr = pc;
        v.ie = e; v.lie = l; v.ack = a; v.exp_is = xis; v.exp_req = xreq;
        vq.push_back(v);
    endtask

    task automatic clear_strobes();
        swi = 2'b00; swi_clr = 2'b00; ti = 1'b0; ti_clr = 1'b0;
        ipi_in = 1'b0; ipi_clr = 1'b0; int_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        hwi_in = 8'h00;
        ie     = 1'b0;
        lie    = 13'h0;
        clear_strobes();

        //   swi    swi_clr ti   ticlr ipi  ipclr ie   lie      ack  exp_is   exp_req
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0000, 1'b0, 13'h0000, 1'b0);
        add(2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0001, 1'b0, 13'h0001, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0001, 1'b0, 13'h0001, 1'b1);
        add(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0001, 1'b0, 13'h0000, 1'b1);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0001, 1'b0, 13'h0000, 1'b0);
        add(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0000, 1'b0, 13'h0800, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0000, 1'b0, 13'h0000, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 13'h0000, 1'b0, 13'h1000, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b0, 13'h0000, 1'b0);
        add(2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 13'h0000, 1'b0, 13'h1802, 1'b0);
        add(2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0800, 1'b0, 13'h1800, 1'b1);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0800, 1'b1, 13'h1800, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0800, 1'b1, 13'h1800, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0800, 1'b0, 13'h1800, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h0800, 1'b0, 13'h1800, 1'b1);
        add(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 13'h0800, 1'b1, 13'h1000, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h1000, 1'b0, 13'h1000, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 13'h1000, 1'b0, 13'h0000, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h1000, 1'b0, 13'h0000, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 13'h1000, 1'b1, 13'h1000, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h1000, 1'b0, 13'h1000, 1'b1);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h1000, 1'b1, 13'h1000, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h1000, 1'b0, 13'h1000, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h1000, 1'b0, 13'h1000, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 13'h1000, 1'b0, 13'h1000, 1'b1);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h1000, 1'b0, 13'h1000, 1'b0);
        add(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h1000, 1'b0, 13'h0000, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_is", 32'(is_o), 32'h0);
        chk("reset_req", 32'(int_req), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            swi = vq[i].swi; swi_clr = vq[i].swi_clr; ti = vq[i].ti; ti_clr = vq[i].ti_clr;
            ipi_in = vq[i].ipi; ipi_clr = vq[i].ipi_clr; ie = vq[i].ie; lie = vq[i].lie;
            int_ack = vq[i].ack;
            tick();
            chk($sformatf("vec%0d_is", i), 32'(is_o), 32'(vq[i].exp_is));
            chk($sformatf("vec%0d_req", i), 32'(int_req), 32'(vq[i].exp_req));
        end
        clear_strobes();
        ie = 1'b0;
        lie = 13'h0;

        // HWI line through the synchroniser, then IE drop while requesting
        ie = 1'b1;
        lie = 13'h020;
        #2 hwi_in = 8'h08;
        tick();
        chk("hwi_edge1_is", 32'(is_o), 32'h0);
        tick();
        chk("hwi_edge2_is", 32'(is_o), 32'h020);
        chk("hwi_edge2_req", 32'(int_req), 32'h0);
        tick();
        chk("hwi_edge3_req", 32'(int_req), 32'h1);
        ie = 1'b0;
        tick();
        chk("hwi_ie_drop_req", 32'(int_req), 32'h0);
        hwi_in = 8'h00;
        tick();
        chk("hwi_fall1_is", 32'(is_o), 32'h020);
        tick();
        chk("hwi_fall2_is", 32'(is_o), 32'h0);
        lie = 13'h0;

        // All sources with LIE masked off
        ie = 1'b1;
        swi = 2'b11; ti = 1'b1; ipi_in = 1'b1; hwi_in = 8'hFF;
        tick();
        chk("all_edge1_is", 32'(is_o), 32'h1803);
        clear_strobes();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("all_is_c%0d", k), 32'(is_o), 32'h1BFF);
            chk($sformatf("all_is10_c%0d", k), 32'(is_o[10]), 32'h0);
            chk($sformatf("all_req_c%0d", k), 32'(int_req), 32'h0);
        end
        swi_clr = 2'b11; ti_clr = 1'b1; ipi_clr = 1'b1; hwi_in = 8'h00;
        tick();
        chk("all_clr1_is", 32'(is_o), 32'h03FC);
        clear_strobes();
        tick();
        chk("all_clr2_is", 32'(is_o), 32'h0);

        // Reset while in BLOCK
        ie = 1'b1;
        lie = 13'h0001;
        swi = 2'b01;
        tick();
        chk("rstblk_is", 32'(is_o), 32'h001);
        swi = 2'b00;
        tick();
        chk("rstblk_req", 32'(int_req), 32'h1);
        int_ack = 1'b1;
        tick();
        chk("rstblk_block_req", 32'(int_req), 32'h0);
        int_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstblk_async_is", 32'(is_o), 32'h0);
        chk("rstblk_async_req", 32'(int_req), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        hwi_in = 8'h00;
        lie = 13'h1FFF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post_rst_req_c%0d", k), 32'(int_req), 32'h0);
            chk($sformatf("post_rst_is_c%0d", k), 32'(is_o), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
